// File: rtl/simple_cnt.sv
// simple_cnt: programmable up-counter with an OBI port for the live count and a register port for control.
// Optional prescaler at offset 0x10 is built when SIMPLE_CNT_PRESCALER_EN is defined.
module simple_cnt #(
    parameter int W = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // OBI slave
    input  logic        slave_req_i,
    input  logic        slave_we_i,
    input  logic [3:0]  slave_be_i,
    input  logic [31:0] slave_addr_i,
    input  logic [31:0] slave_wdata_i,
    output logic        slave_gnt_o,
    output logic        slave_rvalid_o,
    output logic [31:0] slave_rdata_o,
    // Peripheral register bus
    input  logic        reg_valid_i,
    input  logic        reg_write_i,
    input  logic [3:0]  reg_wstrb_i,
    input  logic [31:0] reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic        reg_ready_o,
    output logic        reg_error_o,
    output logic [31:0] reg_rdata_o,
    output logic        cnt_intr_o
);

    localparam logic [9:0] OffCtrl   = 10'h0;
    localparam logic [9:0] OffThresh = 10'h1;
    localparam logic [9:0] OffStatus = 10'h2;
    localparam logic [9:0] OffCount  = 10'h3;
`ifdef SIMPLE_CNT_PRESCALER_EN
    localparam logic [9:0] OffPresc  = 10'h4;
`endif
    localparam logic [W-1:0] CntOne = W'(1);

    function automatic logic [31:0] zext(input logic [W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[W-1:0] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] mergeBytes(input logic [W-1:0] cur,
                                                input logic [31:0] wd,
                                                input logic [3:0]  be);
        logic [W-1:0] r;
        r = cur;
        for (int i = 0; i < W; i++) begin
            if (be[i/8]) r[i] = wd[i];
        end
        return r;
    endfunction

    logic [W-1:0] cnt;
    logic [W-1:0] thresh;
    logic         ctrlEn;
    logic         ctrlIe;
    logic         tc;
    logic         intr;
    logic         obiVld_p1;
    logic [31:0]  obiRdata_p1;

    logic [9:0]   regWord;
    logic         regWr;
    logic         clrPulse;
    logic         ctrlWr;
    logic         threshWr;
    logic         tcClr;
    logic         obiCntSel;
    logic         obiCntWr;
    logic         tick;
    logic         countStep;
    logic         tcSet;
    logic         regHit;
    logic [31:0]  regRdata;
    logic         unusedAddrBits;

    assign regWord   = reg_addr_i[11:2];
    assign regWr     = reg_valid_i & reg_write_i;
    assign clrPulse  = regWr & (regWord == OffCtrl) & reg_wstrb_i[0] & reg_wdata_i[1];
    assign ctrlWr    = regWr & (regWord == OffCtrl) & reg_wstrb_i[0];
    assign threshWr  = regWr & (regWord == OffThresh);
    assign tcClr     = regWr & (regWord == OffStatus) & reg_wstrb_i[0] & reg_wdata_i[0];

    assign obiCntSel = (slave_addr_i[11:2] == 10'h0);
    assign obiCntWr  = slave_req_i & slave_we_i & obiCntSel;

    assign unusedAddrBits = ^{slave_addr_i[31:12], slave_addr_i[1:0],
                              reg_addr_i[31:12], reg_addr_i[1:0]};

`ifdef SIMPLE_CNT_PRESCALER_EN
    logic [W-1:0] presc;
    logic [W-1:0] phase;
    logic         prescWr;

    assign prescWr = regWr & (regWord == OffPresc);
    assign tick    = ctrlEn & (phase == presc);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc <= '0;
            phase <= '0;
        end else begin
            if (prescWr) presc <= mergeBytes(presc, reg_wdata_i, reg_wstrb_i);
            // Phase restarts whenever the count cadence is disturbed
            if (clrPulse || !ctrlEn || prescWr || (phase == presc)) phase <= '0;
            else                                                   phase <= phase + CntOne;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // CLR beats an OBI count write, which beats normal counting
    assign countStep = ctrlEn & tick & ~clrPulse & ~obiCntWr;
    assign tcSet     = countStep & (cnt == thresh);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else begin
            if (clrPulse)       cnt <= '0;
            else if (obiCntWr)  cnt <= mergeBytes(cnt, slave_wdata_i, slave_be_i);
            else if (countStep) cnt <= (cnt == thresh) ? '0 : cnt + CntOne;

            if (tcSet)      tc <= 1'b1;
            else if (tcClr) tc <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrlEn <= 1'b0;
            ctrlIe <= 1'b0;
            thresh <= '0;
            intr   <= 1'b0;
        end else begin
            if (ctrlWr) begin
                ctrlEn <= reg_wdata_i[0];
                ctrlIe <= reg_wdata_i[2];
            end
            if (threshWr) thresh <= mergeBytes(thresh, reg_wdata_i, reg_wstrb_i);
            intr <= tc & ctrlIe;
        end
    end

    // OBI response stage: one cycle behind the grant, data is the pre-update count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            obiVld_p1   <= 1'b0;
            obiRdata_p1 <= '0;
        end else begin
            obiVld_p1   <= slave_req_i;
            obiRdata_p1 <= (slave_req_i && obiCntSel) ? zext(cnt) : 32'h0;
        end
    end

    always_comb begin
        regRdata = '0;
        regHit   = 1'b1;
        case (regWord)
            OffCtrl:   regRdata = {29'h0, ctrlIe, 1'b0, ctrlEn};
            OffThresh: regRdata = zext(thresh);
            OffStatus: regRdata = {31'h0, tc};
            OffCount:  regRdata = zext(cnt);
`ifdef SIMPLE_CNT_PRESCALER_EN
            OffPresc:  regRdata = zext(presc);
`endif
            default:   regHit   = 1'b0;
        endcase
    end

    assign slave_gnt_o    = 1'b1;
    assign slave_rvalid_o = obiVld_p1;
    assign slave_rdata_o  = obiRdata_p1;

    assign reg_ready_o    = 1'b1;
    assign reg_error_o    = reg_valid_i & ~regHit;
    assign reg_rdata_o    = regRdata;

    assign cnt_intr_o     = intr;

endmodule
